// File: rtl/fetch_unit_with_reg.sv
// Program-counter fetch stage: loads jump target, branch target or PC+1 every cycle.
// Latency: one cycle from sampled inputs to pc_out.
// Backpressure: none; the PC advances on every clock edge.

module register_10bit #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else if (en) begin
            dout <= din;
        end
    end

endmodule

module fetch_unit_with_reg #(
    parameter int                PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] branch_addr,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [PC_WIDTH-1:0] pc_out
);

    logic [PC_WIDTH-1:0] next_pc;
    logic                reg_reset;

    // The register's own reset clears to zero, so a nonzero RESET_PC is
    // loaded through the data path instead.
    assign reg_reset = (RESET_PC == '0) ? reset : 1'b0;

    always_comb begin
        next_pc = pc_out + PC_WIDTH'(1);
        if (reset) begin
            next_pc = RESET_PC;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch) begin
            next_pc = branch_addr;
        end
    end

    register_10bit #(
        .WIDTH (PC_WIDTH)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reg_reset),
        .en    (1'b1),
        .din   (next_pc),
        .dout  (pc_out)
    );

endmodule

// File: tb/tb_fetch_unit_with_reg.sv
// Directed bench for fetch_unit_with_reg and a standalone register_10bit.
module tb_fetch_unit_with_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       branch;
    logic       jump;
    logic [9:0] branch_addr;
    logic [9:0] jump_target;
    logic [9:0] pc_out;

    logic       r_reset;
    logic       r_en;
    logic [9:0] r_din;
    logic [9:0] r_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit_with_reg dut (
        .clk         (clk),
        .reset       (reset),
        .branch      (branch),
        .jump        (jump),
        .branch_addr (branch_addr),
        .jump_target (jump_target),
        .pc_out      (pc_out)
    );

    register_10bit u_reg (
        .clk   (clk),
        .reset (r_reset),
        .en    (r_en),
        .din   (r_din),
        .dout  (r_dout)
    );

    typedef struct {
        logic       reset;
        logic       branch;
        logic       jump;
        logic [9:0] branch_addr;
        logic [9:0] jump_target;
        logic [9:0] exp_pc;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%03h), expected %0d (0x%03h)", name, got, got, exp, exp);
        end
    endtask

    function automatic vec_t mk(input logic rs, input logic br, input logic jp,
                                input logic [9:0] ba, input logic [9:0] jt,
                                input logic [9:0] exp, input string name);
        vec_t v;
        v.reset = rs; v.branch = br; v.jump = jp;
        v.branch_addr = ba; v.jump_target = jt; v.exp_pc = exp; v.name = name;
        return v;
    endfunction

    task automatic reg_step(input logic rs, input logic en, input logic [9:0] d,
                            input logic [9:0] exp, input string name);
        @(negedge clk);
        r_reset = rs; r_en = en; r_din = d;
        @(posedge clk);
        #1;
        check(name, r_dout, exp);
    endtask

    initial begin
        logic [9:0] prev_pc;

        reset = 1'b1; branch = 1'b0; jump = 1'b0;
        branch_addr = '0; jump_target = '0;
        r_reset = 1'b0; r_en = 1'b0; r_din = '0;

        vecs.push_back(mk(1, 0, 0,   0,    0,    0, "reset"));
        vecs.push_back(mk(0, 0, 0,   0,    0,    1, "run1"));
        vecs.push_back(mk(0, 0, 0,   0,    0,    2, "run2"));
        vecs.push_back(mk(0, 1, 0, 100,    0,  100, "branch"));
        vecs.push_back(mk(0, 0, 0, 100,    0,  101, "branch+1"));
        vecs.push_back(mk(0, 0, 0, 100,    0,  102, "branch+2"));
        vecs.push_back(mk(0, 0, 1,   0,    3,    3, "jump_to_3"));
        vecs.push_back(mk(0, 0, 0,   0,    0,    4, "run4"));
        vecs.push_back(mk(0, 0, 0,   0,    0,    5, "run5"));
        vecs.push_back(mk(0, 0, 1,   0,  500,  500, "jump500"));
        vecs.push_back(mk(0, 0, 0,   0,  500,  501, "jump+1"));
        vecs.push_back(mk(0, 1, 1, 100,  500,  500, "jump_over_branch"));
        vecs.push_back(mk(1, 0, 1, 100,  500,    0, "reset_over_jump"));
        vecs.push_back(mk(0, 0, 0,   0,    0,    1, "release"));
        vecs.push_back(mk(0, 1, 0,   1,    0,    1, "branch_to_self"));
        vecs.push_back(mk(0, 0, 1,   0, 1022, 1022, "jump1022"));
        vecs.push_back(mk(0, 0, 0,   0,    0, 1023, "pc1023"));
        vecs.push_back(mk(0, 0, 0,   0,    0,    0, "wrap0"));
        vecs.push_back(mk(0, 0, 0,   0,    0,    1, "wrap1"));
        vecs.push_back(mk(0, 1, 0,   7,    0,    7, "branch_hold1"));
        vecs.push_back(mk(0, 1, 0,   7,    0,    7, "branch_hold2"));
        vecs.push_back(mk(0, 0, 0,   7,    0,    8, "after_hold"));

        prev_pc = 'x;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset       = vecs[i].reset;
            branch      = vecs[i].branch;
            jump        = vecs[i].jump;
            branch_addr = vecs[i].branch_addr;
            jump_target = vecs[i].jump_target;
            #1;
            // Inputs must not reach pc_out before the next edge.
            if (i > 0) check({vecs[i].name, "_no_comb"}, pc_out, prev_pc);
            @(posedge clk);
            #1;
            check(vecs[i].name, pc_out, vecs[i].exp_pc);
            prev_pc = vecs[i].exp_pc;
        end

        reg_step(1, 0, 10'h155, 10'h000, "reg_reset");
        reg_step(0, 1, 10'h2AA, 10'h2AA, "reg_load");
        reg_step(0, 0, 10'h155, 10'h2AA, "reg_hold1");
        reg_step(0, 0, 10'h000, 10'h2AA, "reg_hold2");
        reg_step(1, 1, 10'h3FF, 10'h000, "reg_reset_over_en");
        reg_step(0, 1, 10'h3FF, 10'h3FF, "reg_load_max");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
